// File: rtl/dict_finder_pkg.sv
// rtl/dict_finder_pkg.sv - shared types and constants for the dictionary lookup stage
package dict_finder_pkg;

    localparam int DSZ  = 8;
    localparam int ASZ  = 17;
    localparam int NMAX = 31;

    localparam logic [ASZ-1:0] TIB_BASE  = '0;
    localparam logic [ASZ-1:0] DICT_BASE = 17'h00100;

    localparam logic [15:0]    LINK_END  = 16'hffff;
    localparam logic [DSZ-1:0] ASCII_SPC = 8'h20;
    localparam logic [DSZ-1:0] ASCII_NUL = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SKIP,
        ST_TOK,
        ST_LNK0,
        ST_LNK1,
        ST_LEN,
        ST_CMP,
        ST_OPC,
        ST_DONE
    } fnd_st_e;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
    } word_s;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_DUP  = 8'h01,
        OP_DROP = 8'h02,
        OP_SWAP = 8'h03,
        OP_ADD  = 8'h04,
        OP_SUB  = 8'h05
    } opcode_e;

    // Dictionary links are 16 bits; the bus address is wider, so zero-extend.
    function automatic logic [ASZ-1:0] link_addr(input logic [15:0] link);
        return {{(ASZ-16){1'b0}}, link};
    endfunction

endpackage

// File: rtl/mb8_io.sv
// rtl/mb8_io.sv - 8-bit synchronous-read memory bus
interface mb8_io;
    logic                                we;
    logic [dict_finder_pkg::ASZ-1:0]     ai;
    logic [dict_finder_pkg::DSZ-1:0]     vi;
    logic [dict_finder_pkg::DSZ-1:0]     vo;

    modport master (output we, ai, vi, input vo);
    modport slave  (input we, ai, vi, output vo);
endinterface

// File: rtl/dict_finder.sv
// rtl/dict_finder.sv - token scanner and dictionary linked-list walker
module dict_finder
    import dict_finder_pkg::*;
#(
    parameter logic [ASZ-1:0] TIB = TIB_BASE
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mb8_io.master          b8_if,
    input  logic           i_en,
    input  logic [ASZ-1:0] i_tp,
    input  logic [ASZ-1:0] i_ctx,
    output logic           o_bsy,
    output logic           o_done,
    output logic           o_hit,
    output logic           o_eot,
    output logic [7:0]     o_op,
    output logic [ASZ-1:0] o_pfa,
    output logic [ASZ-1:0] o_tib_nx
);

    localparam logic [5:0] NMAX_W = 6'(NMAX);

    fnd_st_e          r_st;
    // r_fill marks the bubble cycle after an address redirect; vo is stale then.
    logic             r_fill;
    logic [ASZ-1:0]   r_ai;
    // Address whose byte is on vo this cycle (r_ai of the previous cycle).
    logic [ASZ-1:0]   r_va;
    logic [ASZ-1:0]   r_ctx;
    word_s            r_link;
    logic [7:0]       r_len;
    logic [5:0]       r_tlen;
    logic [4:0]       r_idx;
    logic             r_ovf;
    logic             r_bsy;
    logic             r_done;
    logic             r_hit;
    logic             r_eot;
    logic [7:0]       r_op;
    logic [ASZ-1:0]   r_pfa;
    logic [ASZ-1:0]   r_tib_nx;
    logic [7:0]       r_tok [0:NMAX-1];

    logic [7:0]       w_vo;
    logic             w_delim;
    logic [7:0]       w_tok_ch;
    logic             w_link_end;
    logic [ASZ-1:0]   w_link_addr;
    logic             w_len_eq;
    logic             w_last;
    logic             w_tok_wr;
    logic [4:0]       w_tok_wa;

    assign w_vo        = b8_if.vo;
    assign w_delim     = (w_vo <= ASCII_SPC);
    assign w_tok_ch    = r_tok[r_idx];
    assign w_link_end  = (r_link == LINK_END);
    assign w_link_addr = link_addr(r_link);
    assign w_len_eq    = (w_vo == {2'b00, r_tlen});
    assign w_last      = ({3'b000, r_idx} == (r_len - 8'd1));

    // First token char lands at slot 0; later chars only while there is room.
    assign w_tok_wr = !r_fill && !w_delim &&
                      ((r_st == ST_SKIP) || ((r_st == ST_TOK) && (r_tlen < NMAX_W)));
    assign w_tok_wa = (r_st == ST_SKIP) ? 5'd0 : r_tlen[4:0];

    // The finder only reads memory.
    assign b8_if.we = 1'b0;
    assign b8_if.vi = '0;
    assign b8_if.ai = r_ai;

    assign o_bsy    = r_bsy;
    assign o_done   = r_done;
    assign o_hit    = r_hit;
    assign o_eot    = r_eot;
    assign o_op     = r_op;
    assign o_pfa    = r_pfa;
    assign o_tib_nx = r_tib_nx;

    // Token buffer capture; contents are only meaningful up to r_tlen.
    always_ff @(posedge i_clk) begin
        if (w_tok_wr) begin
            r_tok[w_tok_wa] <= w_vo;
        end
    end

    // Lookup FSM: one byte read per clock, redirects cost one bubble cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st     <= ST_IDLE;
            r_fill   <= 1'b0;
            r_ai     <= TIB;
            r_va     <= TIB;
            r_ctx    <= '0;
            r_link   <= '0;
            r_len    <= '0;
            r_tlen   <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
            r_bsy    <= 1'b0;
            r_done   <= 1'b0;
            r_hit    <= 1'b0;
            r_eot    <= 1'b0;
            r_op     <= '0;
            r_pfa    <= '0;
            r_tib_nx <= TIB;
        end else begin
            r_va   <= r_ai;
            r_done <= 1'b0;
            if (r_fill) begin
                r_fill <= 1'b0;
                r_ai   <= r_ai + 1'b1;
            end else begin
                case (r_st)
                    ST_IDLE: begin
                        if (i_en) begin
                            r_st   <= ST_SKIP;
                            r_fill <= 1'b1;
                            r_ai   <= i_tp;
                            r_ctx  <= i_ctx;
                            r_tlen <= '0;
                            r_ovf  <= 1'b0;
                            r_bsy  <= 1'b1;
                            r_hit  <= 1'b0;
                            r_eot  <= 1'b0;
                            r_op   <= '0;
                            r_pfa  <= '0;
                        end
                    end
                    ST_SKIP: begin
                        r_ai <= r_ai + 1'b1;
                        if (w_vo == ASCII_NUL) begin
                            r_eot    <= 1'b1;
                            r_tib_nx <= r_va;
                            r_st     <= ST_DONE;
                            r_done   <= 1'b1;
                            r_bsy    <= 1'b0;
                        end else if (!w_delim) begin
                            r_tlen <= 6'd1;
                            r_st   <= ST_TOK;
                        end
                    end
                    ST_TOK: begin
                        if (w_delim) begin
                            r_tib_nx <= r_va;
                            if (r_ovf || (r_ctx == link_addr(LINK_END))) begin
                                r_st   <= ST_DONE;
                                r_done <= 1'b1;
                                r_bsy  <= 1'b0;
                            end else begin
                                r_ai   <= r_ctx;
                                r_fill <= 1'b1;
                                r_st   <= ST_LNK0;
                            end
                        end else begin
                            r_ai <= r_ai + 1'b1;
                            if (r_tlen < NMAX_W) begin
                                r_tlen <= r_tlen + 6'd1;
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    ST_LNK0: begin
                        r_link.lo <= w_vo;
                        r_ai      <= r_ai + 1'b1;
                        r_st      <= ST_LNK1;
                    end
                    ST_LNK1: begin
                        r_link.hi <= w_vo;
                        r_ai      <= r_ai + 1'b1;
                        r_st      <= ST_LEN;
                    end
                    ST_LEN: begin
                        r_len <= w_vo;
                        if (w_len_eq) begin
                            r_idx <= '0;
                            r_ai  <= r_ai + 1'b1;
                            r_st  <= ST_CMP;
                        end else if (w_link_end) begin
                            r_st   <= ST_DONE;
                            r_done <= 1'b1;
                            r_bsy  <= 1'b0;
                        end else begin
                            r_ai   <= w_link_addr;
                            r_fill <= 1'b1;
                            r_st   <= ST_LNK0;
                        end
                    end
                    ST_CMP: begin
                        if (w_vo != w_tok_ch) begin
                            if (w_link_end) begin
                                r_st   <= ST_DONE;
                                r_done <= 1'b1;
                                r_bsy  <= 1'b0;
                            end else begin
                                r_ai   <= w_link_addr;
                                r_fill <= 1'b1;
                                r_st   <= ST_LNK0;
                            end
                        end else begin
                            r_ai <= r_ai + 1'b1;
                            if (w_last) begin
                                r_st <= ST_OPC;
                            end else begin
                                r_idx <= r_idx + 5'd1;
                            end
                        end
                    end
                    ST_OPC: begin
                        r_hit  <= 1'b1;
                        r_op   <= w_vo;
                        r_pfa  <= r_va;
                        r_st   <= ST_DONE;
                        r_done <= 1'b1;
                        r_bsy  <= 1'b0;
                    end
                    ST_DONE: begin
                        r_st <= ST_IDLE;
                    end
                    default: begin
                        r_st <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dict_finder.sv
// tb/tb_dict_finder.sv - self-checking bench for dict_finder
module tb_dict_finder;
    import dict_finder_pkg::*;

    typedef struct packed {
        logic        hit;
        logic        eot;
        logic [7:0]  op;
        logic [16:0] pfa;
        logic [16:0] tib_nx;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [16:0] tp;
    logic [16:0] ctx;
    logic        bsy, done, hit, eot;
    logic [7:0]  op;
    logic [16:0] pfa, tib_nx;

    logic [7:0]  mem [0:131071];
    logic [7:0]  wbuf [$];
    logic [7:0]  tq [$];
    logic [16:0] dict_top, dict_ctx;
    logic [7:0]  nm [0:15][0:3];
    int          nm_len [0:15];
    logic [7:0]  dl [0:3];

    int n_checks = 0;
    int n_fail   = 0;

    mb8_io u_bus ();

    dict_finder u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .b8_if    (u_bus),
        .i_en     (en),
        .i_tp     (tp),
        .i_ctx    (ctx),
        .o_bsy    (bsy),
        .o_done   (done),
        .o_hit    (hit),
        .o_eot    (eot),
        .o_op     (op),
        .o_pfa    (pfa),
        .o_tib_nx (tib_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory
    always @(posedge clk) u_bus.vo <= mem[u_bus.ai];

    function automatic logic [16:0] at(input logic [16:0] b, input int off);
        return 17'(int'(b) + off);
    endfunction

    function automatic res_t mk(input logic h, input logic e, input logic [7:0] o,
                                input logic [16:0] p, input logic [16:0] t);
        return {h, e, o, p, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t got, input res_t exp);
        check({tag, "_hit"},    32'(got.hit),    32'(exp.hit));
        check({tag, "_eot"},    32'(got.eot),    32'(exp.eot));
        check({tag, "_op"},     32'(got.op),     32'(exp.op));
        check({tag, "_pfa"},    32'(got.pfa),    32'(exp.pfa));
        check({tag, "_tib_nx"}, 32'(got.tib_nx), 32'(exp.tib_nx));
    endtask

    task automatic add_entry(input logic [7:0] opc);
        mem[dict_top]          = dict_ctx[7:0];
        mem[at(dict_top, 1)]   = dict_ctx[15:8];
        mem[at(dict_top, 2)]   = 8'(wbuf.size());
        foreach (wbuf[i]) mem[at(dict_top, 3 + i)] = wbuf[i];
        mem[at(dict_top, 3 + wbuf.size())] = opc;
        dict_ctx = dict_top;
        dict_top = at(dict_top, 4 + wbuf.size());
    endtask

    task automatic add_word(input string s, input logic [7:0] opc);
        wbuf.delete();
        for (int i = 0; i < s.len(); i++) wbuf.push_back(s[i]);
        add_entry(opc);
    endtask

    task automatic put_str(input logic [16:0] a, input string s);
        for (int i = 0; i < s.len(); i++) mem[at(a, i)] = s[i];
        mem[at(a, s.len())] = 8'h00;
    endtask

    task automatic put_rep(input logic [16:0] a, input logic [7:0] ch, input int n);
        for (int i = 0; i < n; i++) mem[at(a, i)] = ch;
        mem[at(a, n)] = 8'h00;
    endtask

    // Reference: skip blanks, cut token, walk the list newest-first comparing names.
    task automatic model(input logic [16:0] a_tp, input logic [16:0] a_ctx, output res_t r);
        logic [16:0] a, start, e;
        int tlen, len, guard;
        bit same;
        r = '0;
        a = a_tp;
        while (mem[a] != 8'h00 && mem[a] <= 8'h20) a = at(a, 1);
        if (mem[a] == 8'h00) begin
            r.eot = 1'b1;
            r.tib_nx = a;
            return;
        end
        start = a;
        tlen = 0;
        while (mem[a] > 8'h20) begin
            a = at(a, 1);
            tlen++;
        end
        r.tib_nx = a;
        if (tlen > NMAX) return;
        e = a_ctx;
        guard = 0;
        while (e != 17'h0ffff && guard < 1000) begin
            len = int'(mem[at(e, 2)]);
            if (len == tlen) begin
                same = 1'b1;
                for (int i = 0; i < len; i++)
                    if (mem[at(e, 3 + i)] != mem[at(start, i)]) same = 1'b0;
                if (same) begin
                    r.hit = 1'b1;
                    r.pfa = at(e, 3 + len);
                    r.op  = mem[r.pfa];
                    return;
                end
            end
            e = {1'b0, mem[at(e, 1)], mem[e]};
            guard++;
        end
    endtask

    task automatic lookup(input logic [16:0] a_tp, input logic [16:0] a_ctx, input bit spurious,
                          input string tag, output res_t got, output int cyc);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        tp = a_tp;
        ctx = a_ctx;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        cyc = 1;
        check({tag, "_bsy"}, 32'(bsy), 32'd1);
        while (!seen && cyc < 4000) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                en = spurious && (cyc == 3);
                if (en) tp = at(a_tp, 1);
                @(negedge clk);
                cyc++;
            end
        end
        en = 1'b0;
        check({tag, "_done"}, 32'(seen), 32'd1);
        got = {hit, eot, op, pfa, tib_nx};
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(bsy), 32'd0);
    endtask

    res_t got, exp;
    int   cyc, nd, nw, ntok, kind, k, l, dcount;
    logic [16:0] cur;

    initial begin
        dl[0] = 8'h20; dl[1] = 8'h09; dl[2] = 8'h01; dl[3] = 8'h1f;
        rst_n = 1'b0;
        en    = 1'b0;
        tp    = '0;
        ctx   = '0;
        repeat (2) @(negedge clk);
        check("rst_bsy",    32'(bsy),       32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_hit",    32'(hit),       32'd0);
        check("rst_eot",    32'(eot),       32'd0);
        check("rst_op",     32'(op),        32'd0);
        check("rst_pfa",    32'(pfa),       32'd0);
        check("rst_tib_nx", 32'(tib_nx),    32'd0);
        check("rst_ai",     32'(u_bus.ai),  32'd0);
        check("rst_we",     32'(u_bus.we),  32'd0);
        rst_n = 1'b1;

        dict_top = 17'h00100;
        dict_ctx = 17'h0ffff;
        add_word("nop",  OP_NOP);
        add_word("dup",  OP_DUP);
        add_word("drop", OP_DROP);
        add_word("swap", OP_SWAP);
        add_word("+",    OP_ADD);
        add_word("-",    OP_SUB);
        check("dict_ctx", 32'(dict_ctx), 32'h123);
        put_str(17'h00000, "123 456 +");
        put_str(17'h00020, "dup dip nop dux");

        lookup(17'h0, 17'h123, 1'b1, "t123", got, cyc);
        check_res("t123", got, mk(1'b0, 1'b0, 8'h00, 17'h0, 17'h3));
        lookup(17'h3, 17'h123, 1'b0, "t456", got, cyc);
        check_res("t456", got, mk(1'b0, 1'b0, 8'h00, 17'h0, 17'h7));
        lookup(17'h7, 17'h123, 1'b0, "tadd", got, cyc);
        check_res("tadd", got, mk(1'b1, 1'b0, OP_ADD, 17'h122, 17'h9));
        lookup(17'h9, 17'h123, 1'b0, "teot", got, cyc);
        check_res("teot", got, mk(1'b0, 1'b1, 8'h00, 17'h0, 17'h9));
        check("teot_lat", 32'(cyc <= 3), 32'd1);
        lookup(17'h20, 17'h123, 1'b0, "tdup", got, cyc);
        check_res("tdup", got, mk(1'b1, 1'b0, OP_DUP, 17'h10d, 17'h23));
        lookup(17'h23, 17'h123, 1'b0, "tdip", got, cyc);
        check_res("tdip", got, mk(1'b0, 1'b0, 8'h00, 17'h0, 17'h27));
        lookup(17'h27, 17'h123, 1'b0, "tnop", got, cyc);
        check_res("tnop", got, mk(1'b1, 1'b0, OP_NOP, 17'h106, 17'h2b));

        // Reset while walking the chain for "dux"
        @(negedge clk);
        tp = 17'h2b;
        ctx = 17'h123;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_bsy", 32'(bsy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bsy",    32'(bsy),      32'd0);
        check("mid_rst_done",   32'(done),     32'd0);
        check("mid_rst_tib_nx", 32'(tib_nx),   32'd0);
        check("mid_rst_ai",     32'(u_bus.ai), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("mid_no_done", 32'(dcount), 32'd0);
        check("mid_idle_bsy", 32'(bsy), 32'd0);
        lookup(17'h2b, 17'h123, 1'b0, "tdux", got, cyc);
        check_res("tdux", got, mk(1'b0, 1'b0, 8'h00, 17'h0, 17'h2f));

        // Token length boundary around NMAX
        put_rep(17'h00040, "y", 32);
        put_rep(17'h00070, "y", 31);
        wbuf.delete();
        for (int i = 0; i < 31; i++) wbuf.push_back("y");
        add_entry(8'h77);
        check("dict_ctx2", 32'(dict_ctx), 32'h128);
        lookup(17'h70, dict_ctx, 1'b0, "ty31", got, cyc);
        check_res("ty31", got, mk(1'b1, 1'b0, 8'h77, 17'h14a, 17'h8f));
        lookup(17'h40, dict_ctx, 1'b0, "ty32", got, cyc);
        check_res("ty32", got, mk(1'b0, 1'b0, 8'h00, 17'h0, 17'h60));

        // Address wrap across the top of memory
        mem[17'h1fffe] = 8'h20;
        mem[17'h1ffff] = "-";
        mem[17'h00000] = 8'h20;
        mem[17'h00001] = 8'h00;
        lookup(17'h1fffe, dict_ctx, 1'b0, "twrap", got, cyc);
        check_res("twrap", got, mk(1'b1, 1'b0, OP_SUB, 17'h127, 17'h0));

        // Randomized dictionaries and input lines
        for (int rnd = 0; rnd < 8; rnd++) begin
            dict_top = 17'h00100;
            dict_ctx = 17'h0ffff;
            nw = (rnd == 0) ? 0 : int'($urandom_range(3, 10));
            for (int w = 0; w < nw; w++) begin
                nm_len[w] = int'($urandom_range(1, 3));
                wbuf.delete();
                for (int i = 0; i < nm_len[w]; i++) begin
                    nm[w][i] = 8'("a" + $urandom_range(0, 1));
                    wbuf.push_back(nm[w][i]);
                end
                add_entry(8'($urandom_range(0, 255)));
            end
            tq.delete();
            ntok = int'($urandom_range(2, 6));
            for (int t = 0; t < ntok; t++) begin
                nd = (t == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                for (int i = 0; i < nd; i++) tq.push_back(dl[$urandom_range(0, 3)]);
                kind = int'($urandom_range(0, 9));
                if (kind < 6 && nw > 0) begin
                    k = int'($urandom_range(0, nw - 1));
                    for (int i = 0; i < nm_len[k]; i++) tq.push_back(nm[k][i]);
                end else if (kind < 9) begin
                    l = int'($urandom_range(1, 3));
                    for (int i = 0; i < l; i++) tq.push_back(8'("a" + $urandom_range(0, 1)));
                end else begin
                    l = int'($urandom_range(30, 34));
                    for (int i = 0; i < l; i++) tq.push_back("a");
                end
            end
            nd = int'($urandom_range(0, 2));
            for (int i = 0; i < nd; i++) tq.push_back(dl[$urandom_range(0, 3)]);
            tq.push_back(8'h00);
            foreach (tq[i]) mem[at(17'h02000, i)] = tq[i];

            cur = 17'h02000;
            for (int g = 0; g < 20; g++) begin
                model(cur, dict_ctx, exp);
                lookup(cur, dict_ctx, (g == 1), $sformatf("r%0d_%0d", rnd, g), got, cyc);
                check_res($sformatf("r%0d_%0d", rnd, g), got, exp);
                if (exp.eot) break;
                cur = exp.tib_nx;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
